// File: rtl/anc_frontend_pkg.sv
// Shared definitions for the ANC sample frontend: channel tags, assembler
// states and default sizing.
package anc_frontend_pkg;

   localparam int unsigned W_DEFAULT     = 16;
   localparam int unsigned DEPTH_DEFAULT = 4;

   localparam logic [1:0] CH_X    = 2'd0;
   localparam logic [1:0] CH_E    = 2'd1;
   localparam logic [1:0] CH_A    = 2'd2;
   localparam logic [1:0] CH_RSVD = 2'd3;

   typedef enum logic [1:0] {
      WAIT_X = 2'd0,
      WAIT_E = 2'd1,
      WAIT_A = 2'd2
   } asm_state_e;

endpackage

// File: rtl/anc_frame_fifo.sv
// Synchronous DEPTH-entry frame FIFO; the caller gates push so a push into a
// full FIFO is only issued together with a pop.
module anc_frame_fifo #(
   parameter int unsigned W     = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      push,
   input  logic                      pop,
   input  logic [3*W-1:0]            wdata,
   output logic [3*W-1:0]            rdata,
   output logic                      full,
   output logic                      empty,
   output logic [$clog2(DEPTH):0]    level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam logic [AW:0] FULL_LVL = LW'(DEPTH);

   logic [3*W-1:0] mem_q [DEPTH];
   logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [AW:0]    level_q, level_d;

   always_comb begin
      level_d = level_q;
      unique case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         level_q <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata = mem_q[rd_ptr_q];
   assign full  = (level_q == FULL_LVL);
   assign empty = (level_q == '0);
   assign level = level_q;

endmodule

// File: rtl/anc_sample_frontend.sv
// Channel-tagged sample assembler feeding a frame FIFO and a paced frame
// handshake. Optional dropped-frame counter under ANC_FRONTEND_OVF_CNT_EN.
module anc_sample_frontend
   import anc_frontend_pkg::*;
#(
   parameter int unsigned W     = W_DEFAULT,
   parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      enable,
   input  logic                      smp_valid,
   input  logic [1:0]                smp_ch,
   input  logic [W-1:0]              smp_data,
   input  logic                      err_clr,
   input  logic                      controller_ready,
   output logic                      in_valid,
   output logic [W-1:0]              x_in,
   output logic [W-1:0]              e_in,
   output logic [W-1:0]              a_in,
   output logic [$clog2(DEPTH):0]    fifo_level,
   output logic                      overflow,
   output logic                      frame_err,
   output logic [7:0]                ovf_count
);

   asm_state_e     state_q, state_d;
   logic [W-1:0]   x_q, x_d, e_q, e_d;
   logic           acc, push_req, err_set;

   logic           in_valid_q, overflow_q, err_q;
   logic [W-1:0]   x_out_q, e_out_q, a_out_q;

   logic           fifo_push, fifo_pop, fifo_full, fifo_empty, ovf_evt;
   logic [3*W-1:0] fifo_rdata;

   assign acc = enable && smp_valid && (smp_ch != CH_RSVD);

   // Any unexpected tag drops the partial frame; an x tag restarts one.
   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      e_d      = e_q;
      push_req = 1'b0;
      err_set  = 1'b0;
      if (!enable) begin
         state_d = WAIT_X;
      end else if (acc) begin
         unique case (state_q)
            WAIT_X: begin
               if (smp_ch == CH_X) begin
                  x_d     = smp_data;
                  state_d = WAIT_E;
               end else begin
                  err_set = 1'b1;
               end
            end
            WAIT_E: begin
               if (smp_ch == CH_E) begin
                  e_d     = smp_data;
                  state_d = WAIT_A;
               end else begin
                  err_set = 1'b1;
                  state_d = WAIT_X;
                  if (smp_ch == CH_X) begin
                     x_d     = smp_data;
                     state_d = WAIT_E;
                  end
               end
            end
            WAIT_A: begin
               state_d = WAIT_X;
               if (smp_ch == CH_A) begin
                  push_req = 1'b1;
               end else begin
                  err_set = 1'b1;
                  if (smp_ch == CH_X) begin
                     x_d     = smp_data;
                     state_d = WAIT_E;
                  end
               end
            end
            default: state_d = WAIT_X;
         endcase
      end
   end

   // A push into a full FIFO is only taken when a pop frees the slot this cycle.
   assign fifo_pop  = !fifo_empty && controller_ready && !in_valid_q;
   assign fifo_push = push_req && (!fifo_full || fifo_pop);
   assign ovf_evt   = push_req && fifo_full && !fifo_pop;

   anc_frame_fifo #(
      .W     (W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata ({x_q, e_q, smp_data}),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= WAIT_X;
         x_q        <= '0;
         e_q        <= '0;
         in_valid_q <= 1'b0;
         x_out_q    <= '0;
         e_out_q    <= '0;
         a_out_q    <= '0;
         overflow_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         e_q        <= e_d;
         in_valid_q <= fifo_pop;
         if (fifo_pop) {x_out_q, e_out_q, a_out_q} <= fifo_rdata;
         overflow_q <= ovf_evt;
         err_q      <= err_set | (err_q & ~err_clr);
      end
   end

`ifdef ANC_FRONTEND_OVF_CNT_EN
   logic [7:0] ovf_cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf_cnt_q <= '0;
      end else if (ovf_evt && (ovf_cnt_q != '1)) begin
         ovf_cnt_q <= ovf_cnt_q + 8'd1;
      end
   end

   assign ovf_count = ovf_cnt_q;
`else
   assign ovf_count = '0;
`endif

   assign in_valid  = in_valid_q;
   assign x_in      = x_out_q;
   assign e_in      = e_out_q;
   assign a_in      = a_out_q;
   assign overflow  = overflow_q;
   assign frame_err = err_q;

endmodule

// File: tb/tb_anc_sample_frontend.sv
// Scoreboard bench for anc_sample_frontend: a queue-based reference model
// predicts frames and flags, a negedge monitor compares.
module tb_anc_sample_frontend;

   localparam int W     = 16;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [W-1:0] x;
      logic [W-1:0] e;
      logic [W-1:0] a;
   } frame_t;

   logic         clk;
   logic         rst_n;
   logic         enable;
   logic         smp_valid;
   logic [1:0]   smp_ch;
   logic [W-1:0] smp_data;
   logic         err_clr;
   logic         controller_ready;
   logic         in_valid;
   logic [W-1:0] x_in, e_in, a_in;
   logic [2:0]   fifo_level;
   logic         overflow;
   logic         frame_err;
   logic [7:0]   ovf_count;

   anc_sample_frontend #(
      .W     (W),
      .DEPTH (DEPTH)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .enable           (enable),
      .smp_valid        (smp_valid),
      .smp_ch           (smp_ch),
      .smp_data         (smp_data),
      .err_clr          (err_clr),
      .controller_ready (controller_ready),
      .in_valid         (in_valid),
      .x_in             (x_in),
      .e_in             (e_in),
      .a_in             (a_in),
      .fifo_level       (fifo_level),
      .overflow         (overflow),
      .frame_err        (frame_err),
      .ovf_count        (ovf_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      else n_pass++;
   endtask

   // Reference model state
   frame_t       exp_fifo[$];
   logic [W-1:0] partial[$];
   frame_t       sb_q[$];
   frame_t       exp_out;
   bit           exp_valid, exp_ovf, exp_err, started;
   int           exp_cnt;

   always @(posedge clk) begin
      bit     do_pop, err_set;
      frame_t f;
      started = 1'b1;
      if (!rst_n) begin
         exp_fifo.delete();
         partial.delete();
         sb_q.delete();
         exp_valid = 1'b0;
         exp_out   = '0;
         exp_ovf   = 1'b0;
         exp_err   = 1'b0;
         exp_cnt   = 0;
      end else begin
         err_set = 1'b0;
         exp_ovf = 1'b0;
         do_pop  = (exp_fifo.size() != 0) && controller_ready && !exp_valid;
         if (do_pop) begin
            exp_out = exp_fifo.pop_front();
            sb_q.push_back(exp_out);
         end
         exp_valid = do_pop;
         if (!enable) begin
            partial.delete();
         end else if (smp_valid && smp_ch != 2'd3) begin
            if (int'(smp_ch) == partial.size()) begin
               partial.push_back(smp_data);
               if (partial.size() == 3) begin
                  f.x = partial[0];
                  f.e = partial[1];
                  f.a = partial[2];
                  if (exp_fifo.size() < DEPTH) exp_fifo.push_back(f);
                  else begin
                     exp_ovf = 1'b1;
                     if (exp_cnt < 255) exp_cnt++;
                  end
                  partial.delete();
               end
            end else begin
               err_set = 1'b1;
               partial.delete();
               if (smp_ch == 2'd0) partial.push_back(smp_data);
            end
         end
         if (err_set) exp_err = 1'b1;
         else if (err_clr) exp_err = 1'b0;
      end
   end

   int exp_cnt_out;
   always_comb begin
`ifdef ANC_FRONTEND_OVF_CNT_EN
      exp_cnt_out = exp_cnt;
`else
      exp_cnt_out = 0;
`endif
   end

   always @(negedge clk) begin
      frame_t f;
      if (started) begin
         chk("in_valid", in_valid, exp_valid);
         if (in_valid) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_frame", 1, 0);
            end else begin
               f = sb_q.pop_front();
               chk("frame", {x_in, e_in, a_in}, f);
            end
         end
         chk("out_hold", {x_in, e_in, a_in}, exp_out);
         chk("fifo_level", fifo_level, exp_fifo.size());
         chk("overflow", overflow, exp_ovf);
         chk("frame_err", frame_err, exp_err);
         chk("ovf_count", ovf_count, exp_cnt_out);
      end
   end

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [1:0] ch, input logic [W-1:0] d);
      smp_valid = 1'b1;
      smp_ch    = ch;
      smp_data  = d;
      cyc();
      smp_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [W-1:0] x, input logic [W-1:0] e, input logic [W-1:0] a);
      send(2'd0, x);
      send(2'd1, e);
      send(2'd2, a);
   endtask

   initial begin
      int nch;
      rst_n = 1'b0; enable = 1'b1; smp_valid = 1'b0; smp_ch = '0; smp_data = '0;
      err_clr = 1'b0; controller_ready = 1'b1;
      cyc(3);
      rst_n = 1'b1;
      cyc(2);

      // Basic frame and latency
      send_frame(16'h0100, 16'hFF00, 16'h7FFF);
      cyc(5);

      // Sequencing error then clear
      send(2'd0, 16'h1111); send(2'd2, 16'h2222);
      send(2'd0, 16'h3333); send(2'd1, 16'h4444); send(2'd2, 16'h5555);
      cyc(4);
      err_clr = 1'b1; cyc(); err_clr = 1'b0;
      cyc(2);

      // Overflow with ready low, then drain
      controller_ready = 1'b0;
      for (int i = 0; i < 5; i++) send_frame(16'(i + 16'h10), 16'(i + 16'h20), 16'(i + 16'h30));
      cyc(2);
      controller_ready = 1'b1;
      cyc(12);

      // Full FIFO: push and pop land together
      controller_ready = 1'b0;
      for (int i = 0; i < 4; i++) send_frame(16'(i + 16'h40), 16'(i + 16'h50), 16'(i + 16'h60));
      send(2'd0, 16'hA0A0); send(2'd1, 16'hB0B0);
      controller_ready = 1'b1;
      send(2'd2, 16'hC0C0);
      cyc(14);

      // Reserved tags inside a frame
      send(2'd3, 16'hDEAD); send(2'd0, 16'h0A0A); send(2'd3, 16'hBEEF);
      send(2'd1, 16'h0B0B); send(2'd3, 16'hCAFE); send(2'd2, 16'h0C0C);
      cyc(5);

      // Enable low mid-frame
      send(2'd0, 16'h1234); enable = 1'b0; send(2'd1, 16'h5678); enable = 1'b1;
      send(2'd2, 16'h9ABC);
      cyc(3);

      // Reset mid-frame with frames buffered
      controller_ready = 1'b0;
      send_frame(16'h7001, 16'h7002, 16'h7003);
      send_frame(16'h7011, 16'h7012, 16'h7013);
      send(2'd0, 16'h7021);
      rst_n = 1'b0; cyc(); rst_n = 1'b1;
      controller_ready = 1'b1;
      cyc();
      send_frame(16'h8001, 16'h8002, 16'h8003);
      cyc(5);

      // Randomized traffic
      nch = 0;
      for (int i = 0; i < 2000; i++) begin
         enable           = ($urandom_range(0, 24) != 0);
         controller_ready = ($urandom_range(0, 9) < 6);
         err_clr          = ($urandom_range(0, 19) == 0);
         rst_n            = ($urandom_range(0, 599) != 0);
         smp_valid        = ($urandom_range(0, 3) != 0);
         smp_data         = 16'($urandom());
         if ($urandom_range(0, 9) < 8) smp_ch = 2'(nch);
         else smp_ch = 2'($urandom_range(0, 3));
         if (smp_valid) nch = (nch == 2) ? 0 : nch + 1;
         cyc();
      end
      rst_n = 1'b1; enable = 1'b1; smp_valid = 1'b0; err_clr = 1'b0; controller_ready = 1'b1;
      cyc(12);

      chk("scoreboard_drained", sb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/anc_sample_frontend.md
# anc_sample_frontend

Upstream input stage for the ANC controller/FIR pair. Accepts a time-multiplexed, channel-tagged 16-bit sample stream, assembles ordered {x, e, a} frames, and buffers them in a small frame FIFO. Presents one frame at a time on the controller's `in_valid` / `x_in` / `e_in` / `a_in` inputs, paced by `controller_ready`. Detects sequencing errors and FIFO overflow.

## Interface
Parameters:
- `W`, 16, sample width (signed)
- `DEPTH`, 4, frame FIFO depth (power of two, ≥2)

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; one clock domain, synchronous, active-low
- `enable`  in  1  frontend enable
- `smp_valid`  in  1  input sample strobe
- `smp_ch`  in  2  channel tag: 0 = x, 1 = e, 2 = a, 3 = reserved
- `smp_data`  in  W  signed sample
- `err_clr`  in  1  clears `frame_err`
- `controller_ready`  in  1  downstream ready
- `in_valid`  out  1  frame-valid pulse to controller
- `x_in`, `e_in`, `a_in`  out  W each  frame samples, registered
- `fifo_level`  out  $clog2(DEPTH)+1  frames currently buffered
- `overflow`  out  1  one-cycle pulse on a dropped frame
- `frame_err`  out  1  sticky sequencing-error flag
- `ovf_count`  out  8  saturating count of dropped frames

## Operation
- Assembler FSM states: WAIT_X → WAIT_E → WAIT_A → WAIT_X.
  - A sample is accepted on `smp_valid` with `enable` high.
  - A tag matching the expected channel is stored and the FSM advances.
  - Accepting `a` in WAIT_A pushes {x, e, a} to the FIFO and returns the FSM to WAIT_X.
- Out-of-order tag (0–2, not the expected one):
  - Set `frame_err` and discard the partial frame.
  - If the tag is x, store it and go to WAIT_E; otherwise go to WAIT_X.
  - In WAIT_X, an e or a sample is an error and is discarded.
- Tag 3: ignored, with no state change and no error.
- `enable` low: FSM forced to WAIT_X, partial frame discarded, samples ignored. The FIFO keeps its contents and continues to drain.
- Push when full: the frame is dropped, FIFO contents are unchanged, and `overflow` pulses.
- Pop: when the FIFO is non-empty, `controller_ready` is high, and `in_valid` was low in the previous cycle, the head frame is loaded into the output registers, `in_valid` is driven high for one cycle, and the frame is popped.
  - Outputs hold their last frame until the next pop.
  - Back-to-back frames are at least 2 cycles apart.
- Push and pop in the same cycle: the push is evaluated against the post-pop level. When full, both occur and the level is unchanged.
- `frame_err`: set wins over `err_clr` in the same cycle. Otherwise `err_clr` clears it.

## Timing
- Reset values: `in_valid` 0, `x_in` / `e_in` / `a_in` 0, `fifo_level` 0, `overflow` 0, `frame_err` 0, `ovf_count` 0. FSM resets to WAIT_X. FIFO pointers reset to 0.
- Reset asserted mid-frame or mid-drain: everything returns to the reset values on the next edge, and buffered frames are lost.
- Latency: if the a-sample is accepted at edge k, `fifo_level` increments after edge k, and `in_valid` is earliest high in the cycle after edge k+1 (2 cycles), given the FIFO was empty and `controller_ready` is high.
- All outputs are registered; there is no combinational path from inputs to outputs.
- `controller_ready` is sampled only at the pop decision. Deasserting it while `in_valid` is high does not cancel the transfer.

## Configuration
- `ANC_FRONTEND_OVF_CNT_EN` defined: `ovf_count` increments on every `overflow` pulse and saturates at 255. It is cleared only by reset.
- Not defined: the counter logic is removed and `ovf_count` is tied to 0. The `overflow` pulse is unaffected.

## Structure
- Package `anc_frontend_pkg`:
  - channel codes `CH_X` = 0, `CH_E` = 1, `CH_A` = 2, `CH_RSVD` = 3
  - assembler state typedef
  - default `DEPTH` and `W` constants
- Sub-module `anc_frame_fifo`: synchronous 3×W-wide, DEPTH-entry FIFO with `push`, `pop`, `full`, `empty` and `level`. Read-during-write when full is permitted as specified above.
- The top level contains the assembler FSM, the pop/handshake logic, the error flag and the optional counter.

## Test plan
- x=0x0100, e=0xFF00, a=0x7FFF on consecutive cycles, `controller_ready`=1 → `in_valid` for exactly one cycle, 2 cycles after the a-sample, with `x_in`=0x0100, `e_in`=0xFF00, `a_in`=0x7FFF; `fifo_level` returns to 0.
- Sequence x, a, x, e, a → `frame_err`=1 after the first a. Exactly one frame is output, carrying the second x. `err_clr` then clears the flag.
- `controller_ready`=0; push 5 frames with DEPTH=4 → `fifo_level`=4, one `overflow` pulse on the 5th frame, `ovf_count`=1 (0 without the macro). With ready=1, exactly 4 frames drain in order, spaced 2 cycles apart.
- FIFO full while ready=1: a push and a pop land in the same cycle → no `overflow`, `fifo_level` stays 4.
- Tag-3 samples interleaved within a frame → ignored; the frame is output intact and `frame_err`=0.
- `rst_n` low mid-frame with 2 frames buffered → all outputs 0 and `fifo_level`=0. The next complete frame is output normally.
